brick_map: RTL and testbench

- Owns the brick wall state for Breakout: a ROWS x COLS occupancy bitmap.
- Performs ball-to-brick collision lookup and clears hit bricks.
- Keeps the score and serves per-brick enable reads to the brick renderer.
- Is the writer/owner side of the brick enable interface. The renderer only reads brk_en for a given column/row.

---
 rtl/brick_map_pkg.sv | 26 ++
 rtl/brick_col_div.sv | 46 ++++
 rtl/brick_map.sv | 128 ++++++++++++
 tb/tb_brick_map.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/brick_map_pkg.sv
// rtl/brick_map_pkg.sv - shared brick wall geometry, FSM state encoding and score width
package brick_map_pkg;

  // Geometry shared with the brick renderer
  localparam int COLS    = 6;
  localparam int ROWS    = 8;
  localparam int X0      = 160;
  localparam int BRK_W   = 74;
  localparam int SCORE_W = 8;

  // Sized copies so pixel/index comparisons stay width-matched
  localparam logic [9:0] X0_PX         = 10'(X0);
  localparam logic [9:0] BRK_W_PX      = 10'(BRK_W);
  localparam logic [2:0] COL_LAST      = 3'(COLS - 1);
  localparam logic [3:0] COL_LIM       = 4'(COLS);
  localparam logic [3:0] ROW_LIM       = 4'(ROWS);
  localparam logic [5:0] ROW_FIELD_MAX = 6'(ROWS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_CHECK = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

endpackage

// File: rtl/brick_col_div.sv
// rtl/brick_col_div.sv - iterative subtract-by-BRK_W column locator with start/done handshake
module brick_col_div
  import brick_map_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [9:0] xoff_in,
  output logic       done,
  output logic       miss,
  output logic [2:0] col
);

  logic       active;
  logic [9:0] xoff;
  logic       step_ok;

  // Remainder still spans at least one more brick; stepping past the last column is a miss
  assign step_ok = (xoff >= BRK_W_PX);
  assign done    = active && !step_ok;
  assign miss    = active && step_ok && (col == COL_LAST);

  // Load on start, then strip one brick width per cycle until the remainder fits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      xoff   <= '0;
      col    <= '0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start) begin
      active <= 1'b1;
      xoff   <= xoff_in;
      col    <= '0;
    end else if (active) begin
      if (step_ok && (col != COL_LAST)) begin
        xoff <= xoff - BRK_W_PX;
        col  <= col + 3'd1;
      end else begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/brick_map.sv
// rtl/brick_map.sv - Breakout brick wall owner: collision lookup, clearing, score, renderer reads (option: BRICK_ROW_SCORE_EN)
module brick_map
  import brick_map_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               new_game,
  input  logic               ball_valid,
  input  logic [9:0]         ball_x,
  input  logic [8:0]         ball_y,
  input  logic [2:0]         rd_col,
  input  logic [2:0]         rd_row,
  output logic               brk_en,
  output logic               hit,
  output logic [2:0]         hit_col,
  output logic [2:0]         hit_row,
  output logic [SCORE_W-1:0] score,
  output logic               all_clear,
  output logic               busy
);

  state_t                  state, state_nxt;
  logic [ROWS-1:0][COLS-1:0] bits;
  logic [2:0]              cur_row, cur_col;
  logic [5:0]              y_field;
  logic                    in_range;
  logic                    div_start, div_done, div_miss;
  logic [2:0]              div_col;
  logic [3:0]              score_add;
  logic [SCORE_W:0]        score_sum;
  logic                    unused_y;

  // Rows are 8 pixels tall; row field 0 is the gap above the wall
  assign y_field  = ball_y[8:3];
  assign unused_y = ^ball_y[2:0];
  assign in_range = (ball_x >= X0_PX) && (y_field != 6'd0) && (y_field <= ROW_FIELD_MAX);

`ifdef BRICK_ROW_SCORE_EN
  assign score_add = ROW_LIM - {1'b0, cur_row};
`else
  assign score_add = 4'd1;
`endif
  assign score_sum = {1'b0, score} + {{(SCORE_W - 3){1'b0}}, score_add};

  brick_col_div u_col_div (
    .clk     (clk),
    .reset   (reset),
    .start   (div_start),
    .abort   (new_game),
    .xoff_in (ball_x - X0_PX),
    .done    (div_done),
    .miss    (div_miss),
    .col     (div_col)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next state; new_game aborts whatever is in flight
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ball_valid && in_range) state_nxt = ST_DIV;
      ST_DIV: begin
        if (div_done)      state_nxt = ST_CHECK;
        else if (div_miss) state_nxt = ST_IDLE;
      end
      ST_CHECK: state_nxt = bits[cur_row][cur_col] ? ST_CLEAR : ST_IDLE;
      ST_CLEAR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (new_game) state_nxt = ST_IDLE;
  end

  // FSM outputs: busy flag and divider kick-off
  always_comb begin
    busy      = (state != ST_IDLE);
    div_start = (state == ST_IDLE) && ball_valid && in_range && !new_game;
  end

  // Bitmap, latched brick coordinates, hit pulse and score
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bits    <= '1;
      cur_row <= '0;
      cur_col <= '0;
      hit     <= 1'b0;
      hit_col <= '0;
      hit_row <= '0;
      score   <= '0;
    end else if (new_game) begin
      bits  <= '1;
      hit   <= 1'b0;
      score <= '0;
    end else begin
      hit <= 1'b0;
      if (div_start) cur_row <= y_field[2:0] - 3'd1;
      if ((state == ST_DIV) && div_done) cur_col <= div_col;
      if (state == ST_CLEAR) begin
        bits[cur_row][cur_col] <= 1'b0;
        hit     <= 1'b1;
        hit_col <= cur_col;
        hit_row <= cur_row;
        score   <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      end
    end
  end

  // Renderer read port: one-cycle latency, out-of-range addresses read empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) brk_en <= 1'b0;
    else if (({1'b0, rd_col} < COL_LIM) && ({1'b0, rd_row} < ROW_LIM))
      brk_en <= bits[rd_row][rd_col];
    else
      brk_en <= 1'b0;
  end

  // Wall-empty flag, registered from the bitmap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        all_clear <= 1'b0;
    else if (new_game) all_clear <= 1'b0;
    else               all_clear <= (bits == '0);
  end

endmodule

// File: tb/tb_brick_map.sv
// tb/tb_brick_map.sv - randomized self-checking bench for brick_map against a behavioural wall model
`timescale 1ns/1ps
module tb_brick_map;

  logic       clk = 1'b0;
  logic       reset;
  logic       new_game;
  logic       ball_valid;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic [2:0] rd_col, rd_row;
  logic       brk_en, hit, all_clear, busy;
  logic [2:0] hit_col, hit_row;
  logic [7:0] score;

  int checks   = 0;
  int failures = 0;

  bit model [0:7][0:5];
  int m_score;
  int m_hit_col;
  int m_hit_row;

  brick_map dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .ball_valid (ball_valid),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .brk_en     (brk_en),
    .hit        (hit),
    .hit_col    (hit_col),
    .hit_row    (hit_row),
    .score      (score),
    .all_clear  (all_clear),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic model_fill();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 6; c++)
        model[r][c] = 1'b1;
    m_score = 0;
  endtask

  function automatic int brick_value(input int r);
`ifdef BRICK_ROW_SCORE_EN
    return 8 - r;
`else
    return 1;
`endif
  endfunction

  task automatic read_check(input int r, input int c);
    int expv;
    expv = (r < 8 && c < 6) ? int'(model[r][c]) : 0;
    @(negedge clk);
    rd_row = 3'(r);
    rd_col = 3'(c);
    @(posedge clk);
    #1;
    checks++;
    if (brk_en !== expv[0]) begin
      failures++;
      $display("FAIL read(%0d,%0d): brk_en=%0d expected %0d", r, c, brk_en, expv);
    end
  endtask

  task automatic shot(input int x, input int y);
    int col, yf, exp_k, got_k, hits;
    bit exp_hit;
    yf      = y / 8;
    col     = (x >= 160) ? (x - 160) / 74 : 99;
    exp_hit = (col < 6) && (yf >= 1) && (yf <= 8) && model[yf - 1][col];
    exp_k   = 3 + col;
    @(negedge clk);
    ball_x = 10'(x);
    ball_y = 9'(y);
    ball_valid = 1'b1;
    @(posedge clk);
    #1 ball_valid = 1'b0;
    got_k = -1;
    hits  = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (hit) begin
        hits++;
        if (got_k < 0) got_k = k;
      end
    end
    if (exp_hit) begin
      model[yf - 1][col] = 1'b0;
      m_score = (m_score + brick_value(yf - 1) > 255) ? 255 : m_score + brick_value(yf - 1);
      m_hit_col = col;
      m_hit_row = yf - 1;
    end
    checks++;
    if (exp_hit ? (got_k != exp_k || hits != 1) : (hits != 0)) begin
      failures++;
      $display("FAIL shot(%0d,%0d) hit timing: first cycle %0d count %0d expected cycle %0d count %0d",
               x, y, got_k, hits, exp_hit ? exp_k : -1, exp_hit ? 1 : 0);
    end
    checks++;
    if (hit_col !== 3'(m_hit_col) || hit_row !== 3'(m_hit_row)) begin
      failures++;
      $display("FAIL shot(%0d,%0d) hit_col/row: got %0d/%0d expected %0d/%0d",
               x, y, hit_col, hit_row, m_hit_col, m_hit_row);
    end
    checks++;
    if (score !== 8'(m_score) || busy !== 1'b0) begin
      failures++;
      $display("FAIL shot(%0d,%0d) score/busy: got %0d/%0d expected %0d/0", x, y, score, busy, m_score);
    end
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_fill();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    new_game = 1'b0;
    ball_valid = 1'b0;
    ball_x = '0;
    ball_y = '0;
    rd_col = '0;
    rd_row = '0;
    model_fill();
    m_hit_col = 0;
    m_hit_row = 0;
    #23;
    checks++;
    if (brk_en !== 1'b0 || hit !== 1'b0 || busy !== 1'b0 || all_clear !== 1'b0 ||
        score !== 8'd0 || hit_col !== 3'd0 || hit_row !== 3'd0) begin
      failures++;
      $display("FAIL reset outputs: en=%0d hit=%0d busy=%0d clr=%0d score=%0d col=%0d row=%0d expected all 0",
               brk_en, hit, busy, all_clear, score, hit_col, hit_row);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        read_check(r, c);
  endtask

  task automatic test_directed_hits();
    shot(160, 8);
    read_check(0, 0);
    shot(234, 20);
    shot(234, 20);
    read_check(1, 1);
  endtask

  task automatic test_misses();
    shot(159, 30);
    shot(700, 30);
    shot(200, 5);
    shot(200, 80);
    shot(604, 30);
    shot(603, 70);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      shot(int'($urandom_range(150, 640)), int'($urandom_range(0, 79)));
  endtask

  task automatic test_clear_all();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 6; c++)
        if (model[r][c]) shot(160 + 74 * c + 37, 8 * (r + 1) + 4);
    @(posedge clk);
    #1;
    checks++;
    if (all_clear !== 1'b1 || score !== 8'(m_score)) begin
      failures++;
      $display("FAIL clear_all: all_clear=%0d score=%0d expected 1/%0d", all_clear, score, m_score);
    end
    read_check(4, 3);
    pulse_new_game();
    #1;
    checks++;
    if (all_clear !== 1'b0 || score !== 8'd0) begin
      failures++;
      $display("FAIL new_game refill: all_clear=%0d score=%0d expected 0/0", all_clear, score);
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 6; c++)
        read_check(r, c);
  endtask

  task automatic test_abort();
    int hits;
    @(negedge clk);
    ball_x = 10'd540;
    ball_y = 9'd26;
    ball_valid = 1'b1;
    @(posedge clk);
    #1 ball_valid = 1'b0;
    hits = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      if (hit) hits++;
      new_game = (k == 2);
    end
    new_game = 1'b0;
    checks++;
    if (hits != 0 || score !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort: hits=%0d score=%0d busy=%0d expected 0/0/0", hits, score, busy);
    end
    read_check(2, 5);
    @(negedge clk);
    ball_x = 10'd160;
    ball_y = 9'd8;
    ball_valid = 1'b1;
    new_game = 1'b1;
    @(negedge clk);
    ball_valid = 1'b0;
    new_game = 1'b0;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (hit) hits++;
    end
    checks++;
    if (hits != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL new_game+ball_valid: hits=%0d busy=%0d expected 0/0", hits, busy);
    end
    read_check(0, 0);
  endtask

  task automatic test_back_to_back();
    int hits, got_k;
    @(negedge clk);
    ball_x = 10'd540;
    ball_y = 9'd34;
    ball_valid = 1'b1;
    @(posedge clk);
    #1 ball_x = 10'd160;
    ball_y = 9'd8;
    hits = 0;
    got_k = -1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      ball_valid = 1'b0;
      if (hit) begin
        hits++;
        if (got_k < 0) got_k = k;
      end
    end
    model[3][5] = 1'b0;
    m_score = m_score + brick_value(3);
    checks++;
    if (hits != 1 || got_k != 8 || hit_col !== 3'd5 || hit_row !== 3'd3 || score !== 8'(m_score)) begin
      failures++;
      $display("FAIL busy_ignore: hits=%0d cycle=%0d col=%0d row=%0d score=%0d expected 1/8/5/3/%0d",
               hits, got_k, hit_col, hit_row, score, m_score);
    end
    read_check(0, 0);
    read_check(3, 5);
  endtask

  initial begin
    test_reset();
    test_directed_hits();
    test_misses();
    test_random();
    test_clear_all();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
